// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage control sequencer.
// Arbitrates branch redirects, load-use stalls and debug halt/step.
module fetch_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branchTaken,
    input  logic [31:0]      branchTarget,
    input  logic             exMemRead,
    input  logic [4:0]       exRd,
    input  logic [4:0]       idRs1,
    input  logic [4:0]       idRs2,
    input  logic             haltReq,
    input  logic             stepReq,
    output logic             pcRst,
    output logic             pcEn,
    output logic             branchSel,
    output logic [31:0]      branchVal,
    output logic             ifidEn,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             halted,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALTED,
        S_STEP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [BW-1:0]    r_bootCnt;
    logic             r_stepQ;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    logic w_loadUse;
    logic w_stepPulse;
    logic w_bootDone;
    logic w_stallInc;
    logic w_flushInc;

    assign w_loadUse   = exMemRead && (exRd != 5'd0) &&
                         ((exRd == idRs1) || (exRd == idRs2));
    assign w_stepPulse = stepReq && !r_stepQ;
    assign w_bootDone  = (r_bootCnt == BW'(BOOT_CYCLES - 1));

    // State, boot counter, step edge detector and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_BOOT;
            r_bootCnt  <= '0;
            r_stepQ    <= 1'b0;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            r_state <= w_next;
            r_stepQ <= stepReq;
            if (r_state == S_BOOT)
                r_bootCnt <= r_bootCnt + 1'b1;
            if (w_stallInc && !(&r_stallCnt))
                r_stallCnt <= r_stallCnt + 1'b1;
            if (w_flushInc && !(&r_flushCnt))
                r_flushCnt <= r_flushCnt + 1'b1;
        end
    end

    // Next-state selection; STEP retries while a load-use stall holds
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_BOOT: begin
                if (w_bootDone)
                    w_next = S_RUN;
            end
            S_RUN: begin
                if (!branchTaken && !w_loadUse && haltReq)
                    w_next = S_HALTED;
            end
            S_HALTED: begin
                if (branchTaken)
                    w_next = S_HALTED;
                else if (!haltReq)
                    w_next = S_RUN;
                else if (w_stepPulse)
                    w_next = S_STEP;
            end
            S_STEP: begin
                if (branchTaken || !w_loadUse)
                    w_next = S_HALTED;
            end
            default: w_next = S_BOOT;
        endcase
    end

    // Pipeline control decode; branch wins over stall, stall over halt
    always_comb begin
        pcRst      = 1'b0;
        pcEn       = 1'b0;
        branchSel  = 1'b0;
        ifidEn     = 1'b0;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        halted     = 1'b0;
        w_stallInc = 1'b0;
        w_flushInc = 1'b0;
        if (rst) begin
            pcRst     = 1'b1;
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else begin
            case (r_state)
                S_BOOT: begin
                    pcRst     = 1'b1;
                    ifidFlush = 1'b1;
                    idexFlush = 1'b1;
                end
                S_RUN, S_STEP: begin
                    if (branchTaken) begin
                        branchSel  = 1'b1;
                        pcEn       = 1'b1;
                        ifidFlush  = 1'b1;
                        idexFlush  = 1'b1;
                        w_flushInc = 1'b1;
                    end else if (w_loadUse) begin
                        idexFlush  = 1'b1;
                        w_stallInc = 1'b1;
                    end else if (r_state == S_RUN && haltReq) begin
                        idexFlush = 1'b1;
                    end else begin
                        pcEn   = 1'b1;
                        ifidEn = 1'b1;
                    end
                end
                S_HALTED: begin
                    halted    = 1'b1;
                    idexFlush = 1'b1;
                    if (branchTaken) begin
                        branchSel  = 1'b1;
                        pcEn       = 1'b1;
                        ifidFlush  = 1'b1;
                        w_flushInc = 1'b1;
                    end
                end
                default: begin
                    pcRst = 1'b1;
                end
            endcase
        end
    end

    assign branchVal = branchSel ? branchTarget : 32'd0;
    assign stallCnt  = r_stallCnt;
    assign flushCnt  = r_flushCnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of boot, stall, branch, halt, step
// and counter saturation for fetch_ctrl (CNT_W=4).
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        exMemRead;
    logic [4:0]  exRd, idRs1, idRs2;
    logic        haltReq, stepReq;
    logic        pcRst, pcEn, branchSel;
    logic [31:0] branchVal;
    logic        ifidEn, ifidFlush, idexFlush, halted;
    logic [3:0]  stallCnt, flushCnt;

    int n_chk = 0;
    int n_err = 0;
    int fetches;

    always #5 clk = ~clk;

    fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .exMemRead(exMemRead), .exRd(exRd),
        .idRs1(idRs1), .idRs2(idRs2),
        .haltReq(haltReq), .stepReq(stepReq),
        .pcRst(pcRst), .pcEn(pcEn),
        .branchSel(branchSel), .branchVal(branchVal),
        .ifidEn(ifidEn), .ifidFlush(ifidFlush),
        .idexFlush(idexFlush), .halted(halted),
        .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_lu(input logic on);
        exMemRead = on;
        exRd      = on ? 5'd5 : 5'd0;
        idRs1     = 5'd0;
        idRs2     = on ? 5'd5 : 5'd0;
    endtask

    initial begin
        rst = 1'b1; branchTaken = 1'b0; branchTarget = 32'd0;
        exMemRead = 1'b0; exRd = 5'd0; idRs1 = 5'd0; idRs2 = 5'd0;
        haltReq = 1'b0; stepReq = 1'b0;

        tick(); tick(); tick();
        check("rst_pcRst", pcRst, 1);
        check("rst_pcEn", pcEn, 0);
        check("rst_ifidFlush", ifidFlush, 1);
        check("rst_idexFlush", idexFlush, 1);
        check("rst_halted", halted, 0);

        rst = 1'b0; settle();
        check("boot0_pcRst", pcRst, 1);
        tick();
        check("boot1_pcRst", pcRst, 1);
        check("boot1_pcEn", pcEn, 0);
        tick();
        check("run_pcRst", pcRst, 0);
        check("run_pcEn", pcEn, 1);
        check("run_ifidEn", ifidEn, 1);
        check("run_halted", halted, 0);
        check("run_stallCnt", stallCnt, 0);
        check("run_flushCnt", flushCnt, 0);

        set_lu(1'b1); settle();
        check("lu_pcEn", pcEn, 0);
        check("lu_ifidEn", ifidEn, 0);
        check("lu_idexFlush", idexFlush, 1);
        tick();
        set_lu(1'b0); settle();
        check("lu_stallCnt", stallCnt, 1);
        check("lu_resume_pcEn", pcEn, 1);

        exMemRead = 1'b1; exRd = 5'd0; settle();
        check("x0_pcEn", pcEn, 1);
        check("x0_idexFlush", idexFlush, 0);
        tick();
        check("x0_stallCnt", stallCnt, 1);

        branchTarget = 32'h80; exMemRead = 1'b0; settle();
        check("nobr_branchVal", branchVal, 0);
        check("nobr_branchSel", branchSel, 0);

        branchTaken = 1'b1; set_lu(1'b1); settle();
        check("brlu_branchSel", branchSel, 1);
        check("brlu_branchVal", branchVal, 32'h80);
        check("brlu_pcEn", pcEn, 1);
        check("brlu_ifidFlush", ifidFlush, 1);
        check("brlu_idexFlush", idexFlush, 1);
        tick();
        branchTaken = 1'b0; set_lu(1'b0); settle();
        check("brlu_flushCnt", flushCnt, 1);
        check("brlu_stallCnt", stallCnt, 1);

        haltReq = 1'b1; settle();
        check("hreq_pcEn", pcEn, 0);
        check("hreq_halted", halted, 0);
        tick();
        check("halt_halted", halted, 1);
        check("halt_pcEn", pcEn, 0);
        check("halt_idexFlush", idexFlush, 1);
        branchTaken = 1'b1; branchTarget = 32'h100; settle();
        check("hbr_branchSel", branchSel, 1);
        check("hbr_branchVal", branchVal, 32'h100);
        check("hbr_pcEn", pcEn, 1);
        check("hbr_halted", halted, 1);
        tick();
        branchTaken = 1'b0; settle();
        check("hbr_stay", halted, 1);
        check("hbr_flushCnt", flushCnt, 2);
        haltReq = 1'b0; settle();
        check("hrel_halted", halted, 1);
        tick();
        check("resume_halted", halted, 0);
        check("resume_pcEn", pcEn, 1);

        haltReq = 1'b1; tick();
        check("step_pre_halted", halted, 1);
        fetches = 0;
        stepReq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            if (pcEn) fetches++;
            if (i == 3) stepReq = 1'b0;
            tick();
        end
        check("step_fetches", fetches, 1);
        check("step_post_halted", halted, 1);

        stepReq = 1'b1; settle();
        check("slu_h", halted, 1);
        tick();
        set_lu(1'b1); settle();
        check("slu_pcEn", pcEn, 0);
        check("slu_halted", halted, 0);
        tick();
        set_lu(1'b0); settle();
        check("slu_retry_pcEn", pcEn, 1);
        check("slu_retry_halted", halted, 0);
        check("slu_stallCnt", stallCnt, 2);
        tick();
        check("slu_done_halted", halted, 1);
        check("slu_done_pcEn", pcEn, 0);
        stepReq = 1'b0;

        haltReq = 1'b0; tick();
        check("sat_pre_halted", halted, 0);
        set_lu(1'b1);
        for (int i = 0; i < 20; i++) tick();
        check("sat_stallCnt", stallCnt, 15);

        rst = 1'b1; settle();
        check("mid_rst_pcRst", pcRst, 1);
        check("mid_rst_pcEn", pcEn, 0);
        tick();
        rst = 1'b0; set_lu(1'b0); settle();
        check("post_rst_stallCnt", stallCnt, 0);
        check("post_rst_flushCnt", flushCnt, 0);
        check("post_rst_boot", pcRst, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Control sequencer for the instruction-fetch stage. It drives the PC register reset and enable, the branch-redirect mux select and target, and the IF/ID and ID/EX pipeline-register enable/flush controls. It arbitrates between branch redirects resolved in EX, load-use hazards detected in ID, and an external halt/single-step debug interface. It sits beside the fetch stage and receives status from the ID and EX stages.

Parameters:
BOOT_CYCLES, 2, number of cycles pcRst is held after rst deasserts (minimum 1)
CNT_W, 32, width of the stall and flush performance counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
branchTaken  input  1  EX stage: taken branch or jump this cycle
branchTarget  input  32  EX stage: redirect target address
exMemRead  input  1  EX stage instruction is a load
exRd  input  5  EX stage destination register
idRs1  input  5  ID stage source register 1
idRs2  input  5  ID stage source register 2
haltReq  input  1  level debug halt request
stepReq  input  1  debug single-step request; rising edge acts
pcRst  output  1  PC register reset
pcEn  output  1  PC register enable
branchSel  output  1  redirect mux select (1 = branchVal)
branchVal  output  32  redirect target
ifidEn  output  1  IF/ID register enable
ifidFlush  output  1  IF/ID register clear (bubble)
idexFlush  output  1  ID/EX register clear (bubble)
halted  output  1  controller is in HALTED
stallCnt  output  CNT_W  load-use stall cycles, saturating
flushCnt  output  CNT_W  branch redirects, saturating

Behaviour:
- Reset: one clock, synchronous active-high rst. While rst=1: state<=BOOT, bootCnt<=0, stepReq_q<=0, counters<=0. Outputs while rst=1: pcRst=1, pcEn=0, branchSel=0, branchVal=0, ifidEn=0, ifidFlush=1, idexFlush=1, halted=0.
- Outputs are combinational decodes of state and inputs. Counters and state are registered.
- loadUse = exMemRead & (exRd!=0) & (exRd==idRs1 | exRd==idRs2).
- stepPulse = stepReq & ~stepReq_q. stepReq_q is registered every cycle.
- branchVal = branchTarget when branchSel=1, else 0.
- States: BOOT, RUN, HALTED, STEP.
- BOOT:
  - pcRst=1, pcEn=0, ifidEn=0, ifidFlush=1, idexFlush=1.
  - bootCnt increments each cycle. At bootCnt==BOOT_CYCLES-1 go to RUN.
  - All other inputs are ignored.
- RUN (fixed priority, highest first):
  1. branchTaken: branchSel=1, pcEn=1, ifidFlush=1, idexFlush=1, flushCnt++. Stay in RUN. A branch overrides loadUse and haltReq in the same cycle.
  2. loadUse: pcEn=0, ifidEn=0, idexFlush=1, stallCnt++. Stay in RUN.
  3. haltReq: pcEn=0, ifidEn=0, idexFlush=1. Go to HALTED.
  4. Otherwise: pcEn=1, ifidEn=1, no flush.
- HALTED:
  - halted=1. Front end frozen: pcEn=0, ifidEn=0. idexFlush=1 so downstream stages drain.
  - branchTaken from a draining instruction: branchSel=1, pcEn=1, ifidFlush=1, flushCnt++. Stay in HALTED.
  - Otherwise, haltReq=0: go to RUN.
  - Otherwise, stepPulse: go to STEP.
- STEP:
  - Same decode as RUN priorities 1, 2 and 4. haltReq is ignored.
  - Priority 1 (branch) or 4 (normal fetch): go to HALTED.
  - Priority 2 (loadUse stall): stay in STEP and retry next cycle.
- Counters saturate at all-ones and do not wrap.
- rst asserted in any state, mid-stall or mid-step: immediate return to BOOT. Pending step is lost.

Test Plan:
- Reset/boot, BOOT_CYCLES=2: rst high 3 cycles then low -> pcRst=1 for exactly 2 cycles after deassert. Third cycle: pcEn=1, ifidEn=1, halted=0, counters=0.
- Load-use: exMemRead=1, exRd=5, idRs2=5 for 1 cycle -> pcEn=0, ifidEn=0, idexFlush=1, stallCnt=1. With exRd=0 -> no stall.
- Branch vs stall: branchTaken=1, branchTarget=0x00000080, and loadUse in the same cycle -> branchSel=1, branchVal=0x80, pcEn=1, ifidFlush=1, idexFlush=1, flushCnt=1, stallCnt unchanged.
- Halt/drain: haltReq=1 -> next cycle halted=1, pcEn=0. A branchTaken (target 0x100) while HALTED -> branchSel=1, pcEn=1, still halted. haltReq=0 -> RUN next cycle.
- Single step: in HALTED, stepReq held high 4 cycles -> exactly one pcEn=1 cycle, then halted=1 again. Step coinciding with loadUse -> STEP held one extra cycle, then one fetch.
- Saturation, CNT_W=4: 20 consecutive load-use cycles -> stallCnt stops at 15.
